ipsxe_floating_point_golden_checker: RTL and testbench
======================================================

IPSXE_FLOATING_POINT_GOLDEN_CHECKER -- requirements
Module: ipsxe_floating_point_golden_checker

Interface
REQ-001 Parameter EXP_WIDTH, default 8, SHALL set the exponent field width.
REQ-002 Parameter MAN_WIDTH, default 23, SHALL set the mantissa field width; W = 1+EXP_WIDTH+MAN_WIDTH.
REQ-003 Parameter ADDR_WIDTH, default 4, SHALL set the golden-ROM address width.
REQ-004 Parameter DEPTH, default 4, range 1..2^ADDR_WIDTH, SHALL set the number of vectors checked per run.
REQ-005 Parameter TIMEOUT, default 1024, range ≥1, SHALL set the maximum cycles spent in WAIT per vector.
REQ-006 The block SHALL have one clock, clk, and an asynchronous active-high reset, rst; clk and rst are the first two ports.
REQ-007 Port clk, input, 1, SHALL be the clock; every flop triggers on the rising edge.
REQ-008 Port rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-009 Port start, input, 1, SHALL request a new run.
REQ-010 Port rd_addr, output, ADDR_WIDTH, SHALL drive the external golden ROM address.
REQ-011 Port golden, input, W, SHALL carry ROM data, valid one cycle after rd_addr changes.
REQ-012 Port dut_valid, input, 1, SHALL qualify dut_result.
REQ-013 Port dut_result, input, W, SHALL carry the result under test.
REQ-014 Port dut_ready, output, 1, SHALL indicate that the block accepts a result.
REQ-015 Ports busy, done, pass and timeout, outputs, 1 bit each, SHALL report status.
REQ-016 Port err_cnt, output, ADDR_WIDTH+1, SHALL count mismatches.
REQ-017 Port first_err_addr, output, ADDR_WIDTH, SHALL hold the address of the first mismatch.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, WAIT and DONE.
- IDLE or DONE, start=1: clear err_cnt, first_err_addr and timeout; set rd_addr=0; go to FETCH.
REQ-019 FETCH SHALL last exactly one cycle and then go to WAIT, so that golden matches rd_addr.
REQ-020 In WAIT, dut_ready=1 (combinational from state), and a transfer SHALL be dut_valid&dut_ready.
REQ-021 On a transfer, dut_result SHALL be compared with golden in the same cycle.
- Mismatch: err_cnt increments, saturating at all-ones.
- First mismatch of a run: first_err_addr latches rd_addr.
REQ-022 After a transfer, if rd_addr==DEPTH-1 the FSM SHALL go to DONE; otherwise rd_addr increments and the FSM goes to FETCH.
REQ-023 A cycle counter SHALL reset on entry to WAIT.
- The counter reaching TIMEOUT in WAIT sets timeout=1 and moves the FSM to DONE.
- A transfer in the same cycle as the timeout takes priority over the timeout.
REQ-024 The flag outputs SHALL behave as follows:
- busy=1 in FETCH and WAIT.
- done=1 in DONE only.
- pass = done & (err_cnt==0) & ~timeout.
REQ-025 start SHALL be ignored in FETCH and WAIT.
REQ-026 dut_valid SHALL be ignored outside WAIT, including when it arrives in the same cycle as start.
REQ-027 DONE SHALL hold all results until the next start.
REQ-028 The comparison SHALL be exact bitwise equality over W bits, except as stated in REQ-031.

Reset
REQ-029 While rst=1, the FSM SHALL be IDLE and every output SHALL be 0 (rd_addr, dut_ready, busy, done, pass, timeout, err_cnt, first_err_addr).
REQ-030 Asserting rst mid-run SHALL abort the run immediately with no partial result retained, and after rst deasserts the block SHALL wait for start.

Configuration
REQ-031 Macro IPSXE_FLOATING_POINT_NAN_LOOSE_EN SHALL select the NaN comparison rule.
- Defined: a golden NaN (exponent all ones, mantissa ≠0) matches any NaN dut_result regardless of sign and payload.
- Undefined: NaN is compared bitwise like any other value.

Structure
REQ-032 Package ipsxe_floating_point_checker_pkg SHALL hold the FSM state typedef and an is_nan helper parameterised by the widths.
REQ-033 The compare logic SHALL be a combinational sub-module, ipsxe_floating_point_fp_cmp, with inputs a and b and output match; the macro applies inside it.

Verification
REQ-034 The bench SHALL use DEPTH=4 and golden = {0x40800000, 0x7FC00000, 0x7F800000, 0x00000000}, and SHALL cover the following scenarios:
- Exact DUT results, start pulsed → done=1, pass=1, err_cnt=0, rd_addr ends at 3.
- Vector 2 = 0x7F800001 → err_cnt=1, first_err_addr=2, pass=0.
- Vector 1 = 0xFFC00001 → pass=1 with the macro defined; err_cnt=1 and first_err_addr=1 without it.
- dut_valid never asserted with TIMEOUT=8 → timeout=1, done=1 within 10 cycles of start, pass=0.
- rst asserted in WAIT of vector 1 → all outputs 0 at once; a later start completes normally.
- start pulsed in WAIT, and dut_valid held high in IDLE → both ignored, and the run sequence is unchanged.

Source files
------------

// File: rtl/ipsxe_floating_point_checker_pkg.sv
// Shared types and helpers for the floating-point golden checker.
// is_nan works on any width up to 64 bits; callers zero-extend their operand.
package ipsxe_floating_point_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Exponent all ones with a non-zero mantissa; widths select the field split.
  function automatic logic is_nan(input logic [63:0] v,
                                  input int unsigned exp_w,
                                  input int unsigned man_w);
    logic [63:0] man_mask;
    logic [63:0] exp_mask;
    man_mask = (64'd1 << man_w) - 64'd1;
    exp_mask = ((64'd1 << exp_w) - 64'd1) << man_w;
    return ((v & exp_mask) == exp_mask) && ((v & man_mask) != 64'd0);
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_fp_cmp.sv
// Combinational equality of two floating-point words (a = golden, b = result).
// IPSXE_FLOATING_POINT_NAN_LOOSE_EN lets a golden NaN match any NaN result.
module ipsxe_floating_point_fp_cmp
  import ipsxe_floating_point_checker_pkg::*;
#(
  parameter  int EXP_WIDTH = 8,
  parameter  int MAN_WIDTH = 23,
  localparam int W         = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         match
);

`ifdef IPSXE_FLOATING_POINT_NAN_LOOSE_EN
  logic w_a_nan;
  logic w_b_nan;

  assign w_a_nan = is_nan(64'(a), EXP_WIDTH, MAN_WIDTH);
  assign w_b_nan = is_nan(64'(b), EXP_WIDTH, MAN_WIDTH);
  assign match   = (w_a_nan && w_b_nan) || (a == b);
`else
  assign match = (a == b);
`endif

endmodule

// File: rtl/ipsxe_floating_point_golden_checker.sv
// Walks an external golden ROM and compares each entry against a handshaked result.
// NaN rule is selected by IPSXE_FLOATING_POINT_NAN_LOOSE_EN inside the compare sub-module.
module ipsxe_floating_point_golden_checker
  import ipsxe_floating_point_checker_pkg::*;
#(
  parameter  int EXP_WIDTH  = 8,
  parameter  int MAN_WIDTH  = 23,
  parameter  int ADDR_WIDTH = 4,
  parameter  int DEPTH      = 4,
  parameter  int TIMEOUT    = 1024,
  localparam int W          = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [W-1:0]          golden,
  input  logic                  dut_valid,
  input  logic [W-1:0]          dut_result,
  output logic                  dut_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int                   CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]  ERR_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]  ERR_MAX   = '1;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [ADDR_WIDTH:0]     r_err_cnt;
  logic [ADDR_WIDTH-1:0]   r_first_err_addr;
  logic                    r_timeout;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_match;
  logic                    w_ready;
  logic                    w_xfer;

  ipsxe_floating_point_fp_cmp #(
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_cmp (
    .a     (golden),
    .b     (dut_result),
    .match (w_match)
  );

  // Handshake: a result is accepted in any cycle where dut_valid and dut_ready
  // are both high; dut_ready depends on state only, never on dut_valid.
  assign w_ready = (r_state == WAIT);
  assign w_xfer  = w_ready && dut_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_rd_addr        <= '0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_timeout        <= 1'b0;
      r_cnt            <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_rd_addr        <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_timeout        <= 1'b0;
            r_state          <= FETCH;
          end
        end
        FETCH: begin
          // One cycle for the ROM to return the entry at r_rd_addr.
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_xfer) begin
            if (!w_match) begin
              if (r_err_cnt != ERR_MAX) begin
                r_err_cnt <= r_err_cnt + ERR_ONE;
              end
              if (r_err_cnt == '0) begin
                r_first_err_addr <= r_rd_addr;
              end
            end
            if (r_rd_addr == LAST_ADDR) begin
              r_state <= DONE;
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_ONE;
              r_state   <= FETCH;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_addr        = r_rd_addr;
  assign dut_ready      = w_ready;
  assign busy           = (r_state == FETCH) || (r_state == WAIT);
  assign done           = (r_state == DONE);
  assign pass           = done && (r_err_cnt == '0) && !r_timeout;
  assign timeout        = r_timeout;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_ipsxe_floating_point_golden_checker.sv
// Directed bench: a ROM model and a result responder drive the checker; a monitor
// pops the expected run summary whenever done rises.
module tb_ipsxe_floating_point_golden_checker;

  localparam int W  = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  golden = '0;
  logic          dut_valid = 1'b0;
  logic [W-1:0]  dut_result = '0;
  logic          dut_ready;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] first_err_addr;

  logic [W-1:0]  rom [4];
  logic [W-1:0]  resp_vals [4];
  logic [3:0]    resp_mask = 4'h0;

  int            n_pass = 0;
  int            n_total = 0;
  logic [14:0]   exp_q[$];

  ipsxe_floating_point_golden_checker #(
    .EXP_WIDTH  (8),
    .MAN_WIDTH  (23),
    .ADDR_WIDTH (AW),
    .DEPTH      (4),
    .TIMEOUT    (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .rd_addr        (rd_addr),
    .golden         (golden),
    .dut_valid      (dut_valid),
    .dut_result     (dut_result),
    .dut_ready      (dut_ready),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    rom[0] = 32'h40800000;
    rom[1] = 32'h7FC00000;
    rom[2] = 32'h7F800000;
    rom[3] = 32'h00000000;
  end

  // Synchronous ROM: data follows the address by one cycle.
  initial forever begin
    @(posedge clk);
    golden <= rom[rd_addr[1:0]];
  end

  // Responder: offers the result for the current address when its mask bit is set.
  initial forever begin
    @(negedge clk);
    dut_valid  = resp_mask[rd_addr[1:0]];
    dut_result = resp_vals[rd_addr[1:0]];
  end

  function automatic logic [14:0] pack(input logic p, input logic t, input logic [4:0] e,
                                       input logic [3:0] f, input logic [3:0] r);
    return {p, t, e, f, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_exact();
    for (int i = 0; i < 4; i++) resp_vals[i] = rom[i];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) check("done_wait", 32'(done), 32'd1);
  endtask

  task automatic wait_wait_state(input logic [3:0] addr, input int budget);
    int c;
    c = 0;
    while (!(dut_ready && rd_addr == addr) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!(dut_ready && rd_addr == addr)) check("wait_state_reach", 32'(rd_addr), 32'(addr));
  endtask

  // scoreboard monitor
  initial begin
    logic        prev_done;
    logic [14:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (done && !prev_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("run_result", 32'({pass, timeout, err_cnt, first_err_addr, rd_addr}), 32'(e));
            check("done_flags", 32'({busy, dut_ready}), 32'd0);
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin
    int cyc;
    set_exact();

    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({rd_addr, dut_ready, busy, done, pass, timeout, err_cnt, first_err_addr}), 32'd0);
    rst = 1'b0;

    // dut_valid held high while idle
    resp_mask = 4'hF;
    repeat (4) @(negedge clk);
    check("idle_ignores_valid", 32'({busy, dut_ready, done, err_cnt}), 32'd0);

    // exact results
    exp_q.push_back(pack(1'b1, 1'b0, 5'd0, 4'd0, 4'd3));
    pulse_start();
    wait_done(60, cyc);

    // vector 2 mismatch
    resp_vals[2] = 32'h7F800001;
    exp_q.push_back(pack(1'b0, 1'b0, 5'd1, 4'd2, 4'd3));
    pulse_start();
    wait_done(60, cyc);
    set_exact();

    // NaN with different sign and payload at vector 1
    resp_vals[1] = 32'hFFC00001;
`ifdef IPSXE_FLOATING_POINT_NAN_LOOSE_EN
    exp_q.push_back(pack(1'b1, 1'b0, 5'd0, 4'd0, 4'd3));
`else
    exp_q.push_back(pack(1'b0, 1'b0, 5'd1, 4'd1, 4'd3));
`endif
    pulse_start();
    wait_done(60, cyc);
    set_exact();

    // no response at all: timeout
    resp_mask = 4'h0;
    exp_q.push_back(pack(1'b0, 1'b1, 5'd0, 4'd0, 4'd0));
    pulse_start();
    wait_done(40, cyc);
    check("timeout_latency_le10", 32'(cyc <= 10), 32'd1);

    // reset while waiting on vector 1, after a mismatch on vector 0
    resp_vals[0] = 32'h40800001;
    resp_mask = 4'b1101;
    pulse_start();
    wait_wait_state(4'd1, 30);
    check("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_run_zero",
          32'({rd_addr, dut_ready, busy, done, pass, timeout, err_cnt, first_err_addr}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_exact();
    resp_mask = 4'hF;
    repeat (3) @(negedge clk);
    check("post_rst_stays_idle", 32'({busy, done, err_cnt}), 32'd0);
    exp_q.push_back(pack(1'b1, 1'b0, 5'd0, 4'd0, 4'd3));
    pulse_start();
    wait_done(60, cyc);

    // start pulsed while waiting on vector 2 must not restart the run
    resp_vals[0] = 32'h40800001;
    resp_mask = 4'b1011;
    exp_q.push_back(pack(1'b0, 1'b0, 5'd1, 4'd0, 4'd3));
    pulse_start();
    wait_wait_state(4'd2, 30);
    pulse_start();
    check("start_in_wait_ignored", 32'({busy, rd_addr}), 32'({1'b1, 4'd2}));
    resp_mask = 4'hF;
    wait_done(60, cyc);
    set_exact();

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
